// File: rtl/qam_dist_gen.sv
// qam_dist_gen
//   Candidate generator and squared-distance stage for a 16-QAM two-branch
//   detector. An accepted start captures one I/Q sample set for both branches,
//   then streams all 16 constellation candidates, one per cycle and index 0
//   first. Each beat carries the four per-branch differences and the squared
//   Euclidean distance. The first beat appears two cycles after the accepting
//   edge.
//
//   Optional feature macro: QAM_DIST_SAT_EN
//     defined   : differences and distance saturate (dq_out is never negative)
//     undefined : differences and distance wrap to their N low bits
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   start                    sweep request, sampled only while busy = 0
//   y_I1, y_I2, y_Q1, y_Q2   received samples (signed N), captured on accept
//   busy                     sweep in progress
//   out_valid                candidate beat valid
//   out_last                 high with the q = 15 beat only
//   q_idx                    candidate index of the current beat
//   dq_out                   squared distance (signed N)
//   m_dI1, m_dI2, m_dQ1, m_dQ2  per-branch differences aligned with dq_out
module qam_dist_gen #(
   parameter int N = 32,
   parameter int A = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [N-1:0] y_I1,
   input  logic signed [N-1:0] y_I2,
   input  logic signed [N-1:0] y_Q1,
   input  logic signed [N-1:0] y_Q2,
   output logic                busy,
   output logic                out_valid,
   output logic                out_last,
   output logic [3:0]          q_idx,
   output logic signed [N-1:0] dq_out,
   output logic signed [N-1:0] m_dI1,
   output logic signed [N-1:0] m_dI2,
   output logic signed [N-1:0] m_dQ1,
   output logic signed [N-1:0] m_dQ2
);

   // Difference width (DW) and square/sum width (PW). The wrapping build
   // only ever needs the N low bits, so it keeps all arithmetic at N bits.
`ifdef QAM_DIST_SAT_EN
   localparam int DW = N + 1;
   localparam int PW = 2*N + 2;
   localparam logic signed [PW-1:0] DQ_MAX = PW'({1'b0, {(N-1){1'b1}}});
`else
   localparam int DW = N;
   localparam int PW = N;
`endif

   localparam logic signed [DW-1:0] LVL_1 = DW'(A);
   localparam logic signed [DW-1:0] LVL_3 = DW'(3*A);

   typedef enum logic {
      ST_IDLE,
      ST_SWEEP
   } state_t;

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic [3:0]          cnt_q, cnt_d;
   logic signed [N-1:0] yI1_q, yI1_d;
   logic signed [N-1:0] yI2_q, yI2_d;
   logic signed [N-1:0] yQ1_q, yQ1_d;
   logic signed [N-1:0] yQ2_q, yQ2_d;
   logic                issue;
   logic                issue_last;

   // stage 1
   logic                s1_valid_q;
   logic                s1_last_q;
   logic [3:0]          s1_idx_q;
   logic signed [N-1:0] s1_dI1_q, s1_dI2_q, s1_dQ1_q, s1_dQ2_q;
   logic signed [N-1:0] s1_dI1_d, s1_dI2_d, s1_dQ1_d, s1_dQ2_d;

   // stage 2 / outputs
   logic                ov_q;
   logic                ol_q;
   logic [3:0]          qi_q;
   logic signed [N-1:0] dq_q, dq_d;
   logic signed [N-1:0] oI1_q, oI2_q, oQ1_q, oQ2_q;

   function automatic logic signed [DW-1:0] level(input logic [1:0] k);
      case (k)
         2'd0:    level = -LVL_3;
         2'd1:    level = -LVL_1;
         2'd2:    level = LVL_1;
         default: level = LVL_3;
      endcase
   endfunction

`ifdef QAM_DIST_SAT_EN
   // Overflow shows as the two top bits of the N+1 bit result disagreeing.
   function automatic logic signed [N-1:0] sat_diff(input logic signed [N:0] d);
      if (d[N] != d[N-1])
         sat_diff = d[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else
         sat_diff = d[N-1:0];
   endfunction
`endif

   //------------------------------------------------------------------
   // Control FSM
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         yI1_q   <= '0;
         yI2_q   <= '0;
         yQ1_q   <= '0;
         yQ2_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         yI1_q   <= yI1_d;
         yI2_q   <= yI2_d;
         yQ1_q   <= yQ1_d;
         yQ2_q   <= yQ2_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      cnt_d      = cnt_q;
      yI1_d      = yI1_q;
      yI2_d      = yI2_q;
      yQ1_d      = yQ1_q;
      yQ2_d      = yQ2_q;
      issue      = 1'b0;
      issue_last = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               yI1_d   = y_I1;
               yI2_d   = y_I2;
               yQ1_d   = y_Q1;
               yQ2_d   = y_Q2;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            issue = 1'b1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               issue_last = 1'b1;
               busy_d     = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   //------------------------------------------------------------------
   // Stage 1: candidate differences
   //------------------------------------------------------------------
   always_comb begin
      logic signed [DW-1:0] c_i, c_q;
      logic signed [DW-1:0] w_i1, w_i2, w_q1, w_q2;
      c_i  = level(cnt_q[3:2]);
      c_q  = level(cnt_q[1:0]);
      w_i1 = DW'(yI1_q) - c_i;
      w_i2 = DW'(yI2_q) - c_i;
      w_q1 = DW'(yQ1_q) - c_q;
      w_q2 = DW'(yQ2_q) - c_q;
`ifdef QAM_DIST_SAT_EN
      s1_dI1_d = sat_diff(w_i1);
      s1_dI2_d = sat_diff(w_i2);
      s1_dQ1_d = sat_diff(w_q1);
      s1_dQ2_d = sat_diff(w_q2);
`else
      s1_dI1_d = w_i1;
      s1_dI2_d = w_i2;
      s1_dQ1_d = w_q1;
      s1_dQ2_d = w_q2;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_idx_q   <= '0;
         s1_dI1_q   <= '0;
         s1_dI2_q   <= '0;
         s1_dQ1_q   <= '0;
         s1_dQ2_q   <= '0;
      end else begin
         s1_valid_q <= issue;
         s1_last_q  <= issue_last;
         if (issue) begin
            s1_idx_q <= cnt_q;
            s1_dI1_q <= s1_dI1_d;
            s1_dI2_q <= s1_dI2_d;
            s1_dQ1_q <= s1_dQ1_d;
            s1_dQ2_q <= s1_dQ2_d;
         end
      end
   end

   //------------------------------------------------------------------
   // Stage 2: squared distance
   //------------------------------------------------------------------
   always_comb begin
      logic signed [PW-1:0] sq_i1, sq_i2, sq_q1, sq_q2, sum;
      sq_i1 = PW'(s1_dI1_q) * PW'(s1_dI1_q);
      sq_i2 = PW'(s1_dI2_q) * PW'(s1_dI2_q);
      sq_q1 = PW'(s1_dQ1_q) * PW'(s1_dQ1_q);
      sq_q2 = PW'(s1_dQ2_q) * PW'(s1_dQ2_q);
      sum   = sq_i1 + sq_i2 + sq_q1 + sq_q2;
`ifdef QAM_DIST_SAT_EN
      // The full-precision sum is never negative, so only the upper clamp applies.
      if (sum > DQ_MAX)
         dq_d = {1'b0, {(N-1){1'b1}}};
      else
         dq_d = sum[N-1:0];
`else
      dq_d = sum;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ov_q  <= 1'b0;
         ol_q  <= 1'b0;
         qi_q  <= '0;
         dq_q  <= '0;
         oI1_q <= '0;
         oI2_q <= '0;
         oQ1_q <= '0;
         oQ2_q <= '0;
      end else begin
         ov_q <= s1_valid_q;
         ol_q <= s1_valid_q & s1_last_q;
         if (s1_valid_q) begin
            qi_q  <= s1_idx_q;
            dq_q  <= dq_d;
            oI1_q <= s1_dI1_q;
            oI2_q <= s1_dI2_q;
            oQ1_q <= s1_dQ1_q;
            oQ2_q <= s1_dQ2_q;
         end
      end
   end

   assign busy      = busy_q;
   assign out_valid = ov_q;
   assign out_last  = ol_q;
   assign q_idx     = qi_q;
   assign dq_out    = dq_q;
   assign m_dI1     = oI1_q;
   assign m_dI2     = oI2_q;
   assign m_dQ1     = oQ1_q;
   assign m_dQ2     = oQ2_q;

endmodule

// File: tb/tb_qam_dist_gen.sv
// Testbench for qam_dist_gen (N=32, A=1024). A cycle-based reference model
// tracks sweeps in a queue of expected beats; table vectors and corner-case
// sequences add fixed expected values. Honours QAM_DIST_SAT_EN like the design.
module tb_qam_dist_gen;
   localparam int N = 32;
   localparam int A = 1024;

   logic                clk = 1'b0;
   logic                rst, start;
   logic signed [N-1:0] y_I1, y_I2, y_Q1, y_Q2;
   logic                busy, out_valid, out_last;
   logic [3:0]          q_idx;
   logic signed [N-1:0] dq_out, m_dI1, m_dI2, m_dQ1, m_dQ2;

   always #5 clk = ~clk;

   qam_dist_gen #(.N(N), .A(A)) dut (
      .clk(clk), .rst(rst), .start(start),
      .y_I1(y_I1), .y_I2(y_I2), .y_Q1(y_Q1), .y_Q2(y_Q2),
      .busy(busy), .out_valid(out_valid), .out_last(out_last), .q_idx(q_idx),
      .dq_out(dq_out), .m_dI1(m_dI1), .m_dI2(m_dI2), .m_dQ1(m_dQ1), .m_dQ2(m_dQ2)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   typedef struct {
      int ed;
      int q;
      int d1, d2, d3, d4;
      int dq;
   } beat_t;

   beat_t exq[$];
   int    e   = 0;
   int    acc = -1000;
   bit    m_busy, m_valid, m_last;
   int    m_q, m_dq, m_d1, m_d2, m_d3, m_d4;

   function automatic int lvl(input int k);
      return (2*k - 3) * A;
   endfunction

   function automatic int red_d(input longint d);
`ifdef QAM_DIST_SAT_EN
      if (d > 64'sd2147483647)  return 2147483647;
      if (d < -64'sd2147483648) return int'(-64'sd2147483648);
`endif
      return int'(d);
   endfunction

   function automatic int model_dq(input int a, input int b, input int c, input int d);
      logic signed [127:0] ea, eb, ec, ed, s;
      ea = a; eb = b; ec = c; ed = d;
      s = ea*ea + eb*eb + ec*ec + ed*ed;
`ifdef QAM_DIST_SAT_EN
      if (s > 128'sd2147483647) return 2147483647;
`endif
      return int'(s[31:0]);
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, act, exp);
      end
   endtask

   // Advance one clock edge, update the model, then compare every output.
   task automatic step();
      beat_t b;
      @(posedge clk);
      e++;
      if (rst) begin
         exq.delete();
         acc = -1000;
         m_busy = 0; m_valid = 0; m_last = 0;
         m_q = 0; m_dq = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0; m_d4 = 0;
      end else begin
         if (start && !m_busy) begin
            acc = e;
            for (int q = 0; q < 16; q++) begin
               b.ed = e + 2 + q;
               b.q  = q;
               b.d1 = red_d(longint'(y_I1) - lvl(q / 4));
               b.d2 = red_d(longint'(y_I2) - lvl(q / 4));
               b.d3 = red_d(longint'(y_Q1) - lvl(q % 4));
               b.d4 = red_d(longint'(y_Q2) - lvl(q % 4));
               b.dq = model_dq(b.d1, b.d2, b.d3, b.d4);
               exq.push_back(b);
            end
         end
         m_busy = (e - acc) <= 15;
         if (exq.size() > 0 && exq[0].ed == e) begin
            b = exq.pop_front();
            m_valid = 1; m_last = (b.q == 15);
            m_q = b.q; m_dq = b.dq;
            m_d1 = b.d1; m_d2 = b.d2; m_d3 = b.d3; m_d4 = b.d4;
         end else begin
            m_valid = 0; m_last = 0;
         end
      end
      #1;
      chk("busy",      busy,      m_busy);
      chk("out_valid", out_valid, m_valid);
      chk("out_last",  out_last,  m_last);
      chk("q_idx",     q_idx,     m_q);
      chk("dq_out",    dq_out,    m_dq);
      chk("m_dI1",     m_dI1,     m_d1);
      chk("m_dI2",     m_dI2,     m_d2);
      chk("m_dQ1",     m_dQ1,     m_d3);
      chk("m_dQ2",     m_dQ2,     m_d4);
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      int yi1, yi2, yq1, yq2;
      int q;
      int dq, d1, d2, d3, d4;
   } vec_t;

   vec_t vt[5];
   int cap_dq[16], cap_d1[16], cap_d2[16], cap_d3[16], cap_d4[16];

   task automatic run_sweep(input int a, input int b, input int c, input int d,
                            output int nbeats);
      y_I1 = a; y_I2 = b; y_Q1 = c; y_Q2 = d;
      start = 1'b1;
      step();
      start = 1'b0;
      nbeats = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (out_valid) begin
            cap_dq[q_idx] = dq_out;
            cap_d1[q_idx] = m_dI1;
            cap_d2[q_idx] = m_dI2;
            cap_d3[q_idx] = m_dQ1;
            cap_d4[q_idx] = m_dQ2;
            nbeats++;
         end
      end
   endtask

   initial begin
      int nb, nz, nv, nl, guard;

      vt[0] = '{0, 0, 0, 0, 0, 37748736, 3072, 3072, 3072, 3072};
      vt[1] = '{0, 0, 0, 0, 5, 4194304, 1024, 1024, 1024, 1024};
      vt[2] = '{0, 0, 0, 0, 15, 37748736, -3072, -3072, -3072, -3072};
      vt[3] = '{1024, 1024, -1024, -1024, 9, 0, 0, 0, 0, 0};
`ifdef QAM_DIST_SAT_EN
      vt[4] = '{2147483647, 0, 0, 0, 0, 2147483647, 2147483647, 3072, 3072, 3072};
`else
      vt[4] = '{2147483647, 0, 0, 0, 0, 37742593, -2147480577, 3072, 3072, 3072};
`endif

      rst = 1'b1; start = 1'b0;
      y_I1 = '0; y_I2 = '0; y_Q1 = '0; y_Q2 = '0;
      step(); step();
      rst = 1'b0;
      step();

      // table-driven vectors
      foreach (vt[i]) begin
         run_sweep(vt[i].yi1, vt[i].yi2, vt[i].yq1, vt[i].yq2, nb);
         chk("vec beats", nb, 16);
         chk("vec dq", cap_dq[vt[i].q], vt[i].dq);
         chk("vec dI1", cap_d1[vt[i].q], vt[i].d1);
         chk("vec dI2", cap_d2[vt[i].q], vt[i].d2);
         chk("vec dQ1", cap_d3[vt[i].q], vt[i].d3);
         chk("vec dQ2", cap_d4[vt[i].q], vt[i].d4);
         if (i == 3) begin
            nz = 0;
            for (int q = 0; q < 16; q++) if (cap_dq[q] == 0) nz++;
            chk("unique zero", nz, 1);
         end
      end

      // start held high: back-to-back sweeps, inputs changed mid-sweep
      nv = 0; nl = 0;
      start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i == 8 || i == 25) begin
            y_I1 = $urandom; y_I2 = $urandom; y_Q1 = $urandom; y_Q2 = $urandom;
         end
         step();
         nv += int'(out_valid); nl += int'(out_last);
      end
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         nv += int'(out_valid); nl += int'(out_last);
      end
      chk("held beats", nv, 48);
      chk("held lasts", nl, 3);

      // reset after the q=7 beat
      y_I1 = 5000; y_I2 = -7000; y_Q1 = 123; y_Q2 = -4;
      start = 1'b1;
      step();
      start = 1'b0;
      guard = 0;
      while (!(out_valid && q_idx == 4'd7) && guard < 20) begin
         step();
         guard++;
      end
      chk("reached q7", guard < 20, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst valid", out_valid, 0);
      chk("rst dq", dq_out, 0);
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         nv += int'(out_valid);
      end
      chk("no beats after rst", nv, 0);
      run_sweep(0, 0, 0, 0, nb);
      chk("clean beats", nb, 16);
      chk("clean q0 dq", cap_dq[0], 37748736);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 1) == 0) begin
            y_I1 = $urandom; y_I2 = $urandom; y_Q1 = $urandom; y_Q2 = $urandom;
         end else begin
            y_I1 = $signed($urandom_range(0, 16383)) - 8192;
            y_I2 = $signed($urandom_range(0, 16383)) - 8192;
            y_Q1 = $signed($urandom_range(0, 16383)) - 8192;
            y_Q2 = $signed($urandom_range(0, 16383)) - 8192;
         end
         step();
      end
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 20; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
